// File: rtl/imm_gen_pipe.sv
// Immediate generator with a single registered valid/ready stage.
// Decodes the RISC-V opcode field, builds the sign-extended immediate,
// reports the instruction format and flags unrecognised opcodes.
module imm_gen_pipe #(
  parameter int XLEN     = 64,
  parameter int RV64_OPS = 1,
  parameter int SYS_IMM  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_R    = 3'd6;

  // Widen a 32-bit signed immediate to XLEN by replicating bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic [6:0]      w_opc_p0;
  logic [XLEN-1:0] w_imm_p0;
  logic [2:0]      w_fmt_p0;
  logic            w_ill_p0;
  logic            w_accept_p0;

  logic            r_vld_p1;
  logic [XLEN-1:0] r_imm_p1;
  logic [2:0]      r_fmt_p1;
  logic            r_ill_p1;

  assign w_opc_p0    = instr[6:0];
  assign in_ready    = !r_vld_p1 || out_ready;
  assign w_accept_p0 = in_valid && in_ready && !flush;

  // Combinational opcode decode and immediate assembly.
  always_comb begin
    w_imm_p0 = '0;
    w_fmt_p0 = FMT_NONE;
    w_ill_p0 = 1'b1;
    case (w_opc_p0)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_imm_p0 = sext32({{20{instr[31]}}, instr[31:20]});
        w_fmt_p0 = FMT_I;
        w_ill_p0 = 1'b0;
      end
      7'b0011011: begin
        if (RV64_OPS != 0) begin
          w_imm_p0 = sext32({{20{instr[31]}}, instr[31:20]});
          w_fmt_p0 = FMT_I;
          w_ill_p0 = 1'b0;
        end
      end
      7'b1110011: begin
        if (SYS_IMM != 0) begin
          w_imm_p0 = sext32({{20{instr[31]}}, instr[31:20]});
          w_fmt_p0 = FMT_I;
          w_ill_p0 = 1'b0;
        end
      end
      7'b0100011: begin
        w_imm_p0 = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        w_fmt_p0 = FMT_S;
        w_ill_p0 = 1'b0;
      end
      7'b1100011: begin
        w_imm_p0 = sext32({{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0});
        w_fmt_p0 = FMT_B;
        w_ill_p0 = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        w_imm_p0 = sext32({instr[31:12], 12'b0});
        w_fmt_p0 = FMT_U;
        w_ill_p0 = 1'b0;
      end
      7'b1101111: begin
        w_imm_p0 = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0});
        w_fmt_p0 = FMT_J;
        w_ill_p0 = 1'b0;
      end
      7'b0110011: begin
        w_fmt_p0 = FMT_R;
        w_ill_p0 = 1'b0;
      end
      7'b0111011: begin
        if (RV64_OPS != 0) begin
          w_fmt_p0 = FMT_R;
          w_ill_p0 = 1'b0;
        end
      end
      default: begin
        w_imm_p0 = '0;
      end
    endcase
  end

  // ---- stage p0 -> p1: output register, flush beats accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_imm_p1 <= '0;
      r_fmt_p1 <= FMT_NONE;
      r_ill_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept_p0) begin
      r_vld_p1 <= 1'b1;
      r_imm_p1 <= w_imm_p0;
      r_fmt_p1 <= w_fmt_p0;
      r_ill_p1 <= w_ill_p0;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign imm_out   = r_imm_p1;
  assign fmt       = r_fmt_p1;
  assign illegal   = r_ill_p1;

endmodule
